// File: rtl/onchip_rd_pkg.sv
// Shared defaults and the controller state type for the on-chip RAM stream reader.
//   DefAddrW       : RAM word-address width
//   DefDataW       : RAM / stream data width
//   DefCntW        : word_count width (must cover 2^DefAddrW)
//   DefReadLatency : RAM clocks from address to readdata
//   DefFifoDepth   : output buffer entries
package onchip_rd_pkg;

  localparam int unsigned DefAddrW       = 15;
  localparam int unsigned DefDataW       = 32;
  localparam int unsigned DefCntW        = 16;
  localparam int unsigned DefReadLatency = 1;
  localparam int unsigned DefFifoDepth   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } rd_state_e;

endpackage

// File: rtl/onchip_rd_fifo.sv
// Synchronous FIFO with occupancy count. A write and a pop in the same cycle are both honoured.
// Depth must be a power of two and at least 2.
//   clk_i, rst_i        : clock, asynchronous active-high reset (clears pointers and count)
//   wr_en_i, wr_data_i  : push (dropped only if full and not popping)
//   rd_en_i             : pop the head (ignored when empty)
//   rd_data_o           : head entry
//   empty_o, full_o     : status flags
//   count_o             : number of stored entries
module onchip_rd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [Width-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [Width-1:0]           rd_data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_wr, do_rd;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CntW'(Depth));
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the count gates what is visible.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master that streams a contiguous block of on-chip RAM words onto an Avalon-ST
// source with ready/valid backpressure and SOP/EOP framing.
// Optional feature macro ONCHIP_RD_CHECKSUM_EN adds checksum_o (mod-2^32 sum of sent beats).
//   clk_i, reset_i          : clock, asynchronous active-high reset
//   start_i                 : command strobe, honoured only when idle
//   start_addr_i            : first word address (wraps modulo 2^ADDR_W)
//   word_count_i            : words to read, 0 legal
//   busy_o, done_o          : busy from the cycle after start through done; done is a 1-cycle pulse
//   mem_*                   : RAM read port (write/byteenable/clken are constants)
//   src_*                   : Avalon-ST source
//   checksum_o              : (ONCHIP_RD_CHECKSUM_EN only) sum of transferred beats
module onchip_mem_stream_reader
  import onchip_rd_pkg::*;
#(
  parameter int unsigned ADDR_W       = DefAddrW,
  parameter int unsigned DATA_W       = DefDataW,
  parameter int unsigned CNT_W        = DefCntW,
  parameter int unsigned READ_LATENCY = DefReadLatency,
  parameter int unsigned FIFO_DEPTH   = DefFifoDepth
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [CNT_W-1:0]  word_count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic              mem_chipselect_o,
  output logic              mem_write_o,
  output logic [3:0]        mem_byteenable_o,
  output logic              mem_clken_o,
  input  logic [DATA_W-1:0] mem_readdata_i,
  output logic [DATA_W-1:0] src_data_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic              src_sop_o,
  output logic              src_eop_o
`ifdef ONCHIP_RD_CHECKSUM_EN
  ,
  output logic [31:0]       checksum_o
`endif
);

  localparam int unsigned FcW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OccW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

  rd_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [CNT_W-1:0]      remaining_q, remaining_d;
  logic [CNT_W-1:0]      total_q, total_d;
  logic [CNT_W-1:0]      beats_q, beats_d;
  logic [READ_LATENCY-1:0] inflight_q, inflight_d;

  logic [DATA_W-1:0]     fifo_rdata;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [FcW-1:0]        fifo_count;
  logic [OccW-1:0]       inflight_cnt;
  logic [OccW-1:0]       occupancy;
  logic                  issue;
  logic                  pop;
  logic                  last_beat;

  // Reads in flight plus buffered words must never exceed the buffer, so the RAM pipe can
  // always land its data without a full check.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + OccW'(inflight_q[i]);
    end
  end

  assign occupancy = OccW'(fifo_count) + inflight_cnt;
  assign issue     = (state_q == StRun) && (remaining_q != '0) &&
                     (occupancy < OccW'(FIFO_DEPTH));
  assign pop       = !fifo_empty && src_ready_i;
  assign last_beat = (beats_q == total_q - CNT_W'(1));

  onchip_rd_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (DATA_W)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (reset_i),
    .wr_en_i   (inflight_q[READ_LATENCY-1]),
    .wr_data_i (mem_readdata_i),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rdata),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .count_o   (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    total_d     = total_q;
    beats_d     = beats_q;
    inflight_d  = inflight_q << 1;
    inflight_d[0] = issue;

    if (issue) begin
      addr_d      = addr_q + ADDR_W'(1);
      remaining_d = remaining_q - CNT_W'(1);
    end
    if (pop) beats_d = beats_q + CNT_W'(1);

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d      = start_addr_i;
          remaining_d = word_count_i;
          total_d     = word_count_i;
          beats_d     = '0;
          state_d     = (word_count_i == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (issue && (remaining_q == CNT_W'(1))) state_d = StDrain;
      end
      StDrain: begin
        if (pop && last_beat) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      total_q     <= '0;
      beats_q     <= '0;
      inflight_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      total_q     <= total_d;
      beats_q     <= beats_d;
      inflight_q  <= inflight_d;
    end
  end

`ifdef ONCHIP_RD_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == StIdle && start_i) begin
      checksum_d = '0;
    end else if (pop) begin
      checksum_d = checksum_q + 32'(fifo_rdata);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) checksum_q <= '0;
    else         checksum_q <= checksum_d;
  end

  assign checksum_o = checksum_q;
`endif

  assign busy_o           = (state_q != StIdle);
  assign done_o           = (state_q == StDone);
  assign mem_address_o    = addr_q;
  assign mem_chipselect_o = issue;
  assign mem_write_o      = 1'b0;
  assign mem_byteenable_o = 4'hF;
  assign mem_clken_o      = 1'b1;

  // Unreset FIFO storage must not leak onto the bus while nothing is valid.
  assign src_valid_o = !fifo_empty;
  assign src_data_o  = fifo_empty ? '0 : fifo_rdata;
  assign src_sop_o   = !fifo_empty && (beats_q == '0);
  assign src_eop_o   = !fifo_empty && last_beat;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Scoreboard bench for onchip_mem_stream_reader: stimulus pushes expected read addresses and
// beats into queues; negedge monitors pop and compare whenever the DUT reads or transfers.
module tb_onchip_mem_stream_reader;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [14:0] start_addr;
  logic [15:0] word_count;
  logic        busy, done;
  logic [14:0] mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata;
  logic [31:0] src_data;
  logic        src_valid, src_ready, src_sop, src_eop;
`ifdef ONCHIP_RD_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  logic [31:0] ram [32768];
  beat_t       exp_q [$];
  logic [14:0] addr_exp_q [$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int issued  = 0;
  int popped  = 0;
  int beats_seen = 0;
  int first_beat_cyc = 0;
  int last_eop_cyc   = 0;
  logic ready_mode = 1'b0;

  onchip_mem_stream_reader dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .start_i          (start),
    .start_addr_i     (start_addr),
    .word_count_i     (word_count),
    .busy_o           (busy),
    .done_o           (done),
    .mem_address_o    (mem_address),
    .mem_chipselect_o (mem_chipselect),
    .mem_write_o      (mem_write),
    .mem_byteenable_o (mem_byteenable),
    .mem_clken_o      (mem_clken),
    .mem_readdata_i   (mem_readdata),
    .src_data_o       (src_data),
    .src_valid_o      (src_valid),
    .src_ready_i      (src_ready),
    .src_sop_o        (src_sop),
    .src_eop_o        (src_eop)
`ifdef ONCHIP_RD_CHECKSUM_EN
    ,
    .checksum_o       (checksum)
`endif
  );

  always #5 clk = ~clk;

  // RAM model, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= ram[mem_address];
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // src_ready driver: held high, or cycling 1,0,0,1.
  initial begin
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph = 0;
    src_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode) begin
        src_ready = pat[ph];
        ph = (ph + 1) % 4;
      end else begin
        src_ready = 1'b1;
      end
    end
  end

  // Monitor: read addresses, occupancy bound, beats, and data hold under backpressure.
  initial begin
    beat_t       e;
    logic        stall;
    logic [31:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (mem_chipselect) begin
          chk("occupancy_le_4", ((issued - popped + 1) <= 4), 1);
          if (addr_exp_q.size() == 0) fail_now("unexpected_read");
          else chk("rd_addr", mem_address, addr_exp_q.pop_front());
          issued++;
        end
        if (stall) begin
          chk("hold_valid", src_valid, 1);
          chk("hold_data", src_data, held);
        end
        if (src_valid && src_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_beat");
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", src_data, e.data);
            chk("beat_sop", src_sop, e.sop);
            chk("beat_eop", src_eop, e.eop);
          end
          if (src_sop) first_beat_cyc = cyc;
          if (src_eop) last_eop_cyc = cyc;
          popped++;
          beats_seen++;
        end
        stall = src_valid && !src_ready;
        held  = src_data;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cs"}, mem_chipselect, 0);
    chk({tag, "_addr"}, mem_address, 0);
    chk({tag, "_write"}, mem_write, 0);
    chk({tag, "_be"}, mem_byteenable, 4'hF);
    chk({tag, "_clken"}, mem_clken, 1);
    chk({tag, "_valid"}, src_valid, 0);
    chk({tag, "_data"}, src_data, 0);
    chk({tag, "_sop"}, src_sop, 0);
    chk({tag, "_eop"}, src_eop, 0);
  endtask

  // Queue expectations, pulse start for one cycle; s is the cycle start is held high.
  task automatic run_xfer(input logic [14:0] a, input logic [15:0] n, output int s);
    beat_t b;
    logic [14:0] ad;
    for (int i = 0; i < int'(n); i++) begin
      ad = a + 15'(i);
      addr_exp_q.push_back(ad);
      b.data = ram[ad];
      b.sop  = (i == 0);
      b.eop  = (i == int'(n) - 1);
      exp_q.push_back(b);
    end
    @(posedge clk);
    #1;
    start = 1'b1;
    start_addr = a;
    word_count = n;
    s = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    bit found;
    found = 1'b0;
    dcyc = -1;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        dcyc = cyc;
      end
    end
    if (!found) begin
      fail_now("done_timeout");
    end else begin
      @(negedge clk);
      chk("done_single_pulse", done, 0);
      chk("busy_after_done", busy, 0);
    end
  endtask

  initial begin
    int s, d, base;
    for (int i = 0; i < 32768; i++) ram[i] = 32'(i);
    reset = 1'b1;
    start = 1'b0;
    start_addr = '0;
    word_count = '0;
    #1;
    check_reset_vals("por");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // 8 words from 0x10 at full rate.
    run_xfer(15'h0010, 16'd8, s);
    chk("busy_after_start", busy, 1);
    wait_done(d);
    chk("first_beat_latency", first_beat_cyc - s, 3);
    chk("done_cycle_8", d - s, 11);
    chk("done_after_eop", d, last_eop_cyc + 1);
    chk("queue_empty_1", exp_q.size(), 0);

    // Same transfer with ready toggling 1,0,0,1.
    ready_mode = 1'b1;
    run_xfer(15'h0010, 16'd8, s);
    wait_done(d);
    chk("done_after_eop_bp", d, last_eop_cyc + 1);
    chk("queue_empty_bp", exp_q.size(), 0);
    ready_mode = 1'b0;

    // Address wrap.
    run_xfer(15'h7FFE, 16'd4, s);
    wait_done(d);
    chk("done_cycle_wrap", d - s, 7);
    chk("addr_queue_empty_wrap", addr_exp_q.size(), 0);

    // Zero-length: done only, no reads.
    run_xfer(15'h0055, 16'd0, s);
    wait_done(d);
    chk("done_cycle_zero", d - s, 1);

    // Single word: sop and eop together.
    run_xfer(15'h0123, 16'd1, s);
    wait_done(d);
    chk("done_cycle_one", d - s, 4);
    chk("queue_empty_one", exp_q.size(), 0);

    // Reset after 3 of 8 beats.
    base = beats_seen;
    run_xfer(15'h0000, 16'd8, s);
    for (int k = 0; k < 100 && (beats_seen - base) < 3; k++) begin
      @(posedge clk);
      #1;
    end
    chk("beats_before_reset", beats_seen - base, 3);
    reset = 1'b1;
    #1;
    check_reset_vals("midreset");
    exp_q.delete();
    addr_exp_q.delete();
    issued = 0;
    popped = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("no_done_after_reset", done, 0);

    // Clean restart; a start pulsed mid-transfer must be ignored.
    run_xfer(15'h0020, 16'd2, s);
    start = 1'b1;
    start_addr = 15'h0100;
    word_count = 16'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(d);
    chk("done_cycle_restart", d - s, 5);

`ifdef ONCHIP_RD_CHECKSUM_EN
    ram[15'h0040] = 32'hFFFF_FFFF;
    ram[15'h0041] = 32'h0000_0002;
    run_xfer(15'h0040, 16'd2, s);
    wait_done(d);
    chk("checksum", checksum, 32'h0000_0001);
`endif

    repeat (5) @(negedge clk);
    chk("final_beat_queue_empty", exp_q.size(), 0);
    chk("final_addr_queue_empty", addr_exp_q.size(), 0);
    chk("final_idle", busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
